// File: rtl/wishbone_slave_xactor_p_if.sv
// Wishbone B4 pipelined bus bundle between a master and wishbone_slave_xactor_p.
// Signal names keep the slave-side _I/_O suffixes so both ends read the same.
interface wishbone_slave_xactor_p_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  CYC_I;
  logic                  STB_I;
  logic                  WE_I;
  logic [ADDR_W-1:0]     ADR_I;
  logic [DATA_W/8-1:0]   SEL_I;
  logic [DATA_W-1:0]     DAT_I;
  logic                  STALL_O;
  logic                  ACK_O;
  logic                  ERR_O;
  logic [DATA_W-1:0]     DAT_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    input  STALL_O, ACK_O, ERR_O, DAT_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    output STALL_O, ACK_O, ERR_O, DAT_O
  );
endinterface

// File: rtl/wishbone_slave_xactor_p.sv
// Wishbone B4 pipelined slave transactor: bus requests go to a client through a request
// FIFO, client responses come back as ACK_O/ERR_O; responses owed to aborted cycles are discarded.
module wishbone_slave_xactor_p #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int REQ_DEPTH       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  wishbone_slave_xactor_p_if.slave             wb,
  output logic [1+DATA_W/8+ADDR_W+DATA_W-1:0]  client_request_get,
  output logic                                 RDY_client_request_get,
  input  logic                                 EN_client_request_get,
  input  logic [DATA_W:0]                      client_response_put,
  input  logic                                 EN_client_response_put,
  output logic                                 RDY_client_response_put
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int REQ_W  = 1 + SEL_W + ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int OUT_W  = ((CNT_W > FCNT_W) ? CNT_W : FCNT_W) + 1;

  logic [REQ_W-1:0]  fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  live_q, live_d;
  logic [CNT_W-1:0]  stale_q, stale_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  logic              fifo_full;
  logic [OUT_W-1:0]  outstanding;
  logic              stall;
  logic              accept;
  logic              req_rdy;
  logic              pop;
  logic              rsp_rdy;
  logic              rsp_fire;
  logic              rsp_stale;
  logic              rsp_live;
  logic              rsp_err;

  // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
  always_comb begin
    fifo_full   = (fifo_cnt_q == FCNT_W'(REQ_DEPTH));
    outstanding = OUT_W'(fifo_cnt_q) + OUT_W'(live_q);
    stall       = fifo_full | (outstanding == OUT_W'(MAX_OUTSTANDING));
    accept      = wb.CYC_I & wb.STB_I & ~stall;
    req_rdy     = (fifo_cnt_q != '0) & wb.CYC_I;
    pop         = EN_client_request_get & req_rdy;
    rsp_rdy     = (live_q != '0) | (stale_q != '0);
    rsp_fire    = EN_client_response_put & rsp_rdy;
    // Stale answers belong to aborted cycles and always drain before live ones.
    rsp_stale   = rsp_fire & (stale_q != '0);
    rsp_live    = rsp_fire & (stale_q == '0);
    rsp_err     = client_response_put[DATA_W];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + FCNT_W'(accept) - FCNT_W'(pop);
    live_d     = live_q + CNT_W'(pop) - CNT_W'(rsp_live);
    stale_d    = stale_q - CNT_W'(rsp_stale);
    if (!wb.CYC_I) begin
      // Abort: unread requests vanish, anything the client already holds becomes stale.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      live_d     = '0;
      stale_d    = stale_q - CNT_W'(rsp_stale) + live_q - CNT_W'(rsp_live);
    end
    ack_d = rsp_live & wb.CYC_I & ~rsp_err;
    err_d = rsp_live & wb.CYC_I & rsp_err;
    dat_d = (rsp_live & wb.CYC_I) ? client_response_put[DATA_W-1:0] : dat_q;
  end

  // NOTE: the storage array has no reset; fifo_cnt_q alone decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= {wb.WE_I, wb.SEL_I, wb.ADR_I, wb.DAT_I};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      live_q     <= '0;
      stale_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      live_q     <= live_d;
      stale_q    <= stale_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign wb.STALL_O                = stall;
  assign wb.ACK_O                  = ack_q;
  assign wb.ERR_O                  = err_q;
  assign wb.DAT_O                  = dat_q;
  assign client_request_get        = fifo_mem[rd_ptr_q];
  assign RDY_client_request_get    = req_rdy;
  assign RDY_client_response_put   = rsp_rdy;

endmodule

// File: tb/tb_wishbone_slave_xactor_p.sv
// Directed bench for wishbone_slave_xactor_p built with REQ_DEPTH=2, MAX_OUTSTANDING=4 so
// both the FIFO-full and outstanding-limit stalls are reachable in a few cycles.
module tb_wishbone_slave_xactor_p;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + DATA_W/8 + ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_slave_xactor_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  logic [REQ_W-1:0]  req_get;
  logic              req_rdy;
  logic              req_en;
  logic [DATA_W:0]   rsp_put;
  logic              rsp_en;
  logic              rsp_rdy;

  wishbone_slave_xactor_p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(2), .MAX_OUTSTANDING(4)
  ) dut (
    .CLK                     (clk),
    .RST                     (rst),
    .wb                      (wb),
    .client_request_get      (req_get),
    .RDY_client_request_get  (req_rdy),
    .EN_client_request_get   (req_en),
    .client_response_put     (rsp_put),
    .EN_client_response_put  (rsp_en),
    .RDY_client_response_put (rsp_rdy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Burst reference model state
  logic [REQ_W-1:0] q_req [$];
  int               efifo, elive, sent, resp, dut_acks;
  logic             exp_ack;
  logic [31:0]      exp_dat;
  logic             exp_stall;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    wb.ADR_I = '0;   wb.SEL_I = '0;   wb.DAT_I = '0;
    req_en = 1'b0; rsp_en = 1'b0; rsp_put = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr; wb.SEL_I = 4'hf; wb.DAT_I = dat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    idle_bus();
    repeat (2) @(posedge clk);
    next(); rst = 1'b0; #1;
    check("rst_ack",     wb.ACK_O,   0);
    check("rst_err",     wb.ERR_O,   0);
    check("rst_dat",     wb.DAT_O,   0);
    check("rst_stall",   wb.STALL_O, 0);
    check("rst_req_rdy", req_rdy,    0);
    check("rst_rsp_rdy", rsp_rdy,    0);

    // ---------------- single read ----------------
    next(); wb.CYC_I = 1'b1; drive_req(1'b0, 32'h10, 32'h0); #1;
    check("rd_stall",      wb.STALL_O, 0);
    check("rd_req_rdy_pre", req_rdy,   0);
    next(); wb.STB_I = 1'b0; req_en = 1'b1; #1;
    check("rd_req_rdy", req_rdy, 1);
    check("rd_entry",   req_get, {1'b0, 4'hf, 32'h10, 32'h0});
    next(); req_en = 1'b0; rsp_en = 1'b1; rsp_put = {1'b0, 32'hCAFEF00D}; #1;
    check("rd_req_rdy_post", req_rdy, 0);
    check("rd_rsp_rdy",      rsp_rdy, 1);
    check("rd_ack_early",    wb.ACK_O, 0);
    next(); rsp_en = 1'b0; #1;
    check("rd_ack",     wb.ACK_O, 1);
    check("rd_err",     wb.ERR_O, 0);
    check("rd_dat",     wb.DAT_O, 32'hCAFEF00D);
    check("rd_rsp_idle", rsp_rdy, 0);
    next(); #1;
    check("rd_ack_pulse", wb.ACK_O, 0);
    check("rd_dat_hold",  wb.DAT_O, 32'hCAFEF00D);

    // ---------------- pipelined write burst, client responds late ----------------
    efifo = 0; elive = 0; sent = 0; resp = 0; dut_acks = 0;
    exp_ack = 1'b0; exp_dat = '0;
    for (int c = 0; c < 40; c++) begin
      next();
      wb.STB_I = (sent < 8); wb.WE_I = 1'b1; wb.SEL_I = 4'hf;
      wb.ADR_I = 32'h100 + 32'(4 * sent); wb.DAT_I = 32'hA0 + 32'(sent);
      req_en   = (efifo > 0);
      rsp_en   = (c >= 6) && (elive > 0);
      rsp_put  = {1'b0, 32'h5000 + 32'(resp)};
      #1;
      exp_stall = (efifo == 2) || (efifo + elive == 4);
      check("burst_stall", wb.STALL_O, exp_stall);
      if (c == 4) check("burst_stall_after_4", wb.STALL_O, 1);
      if (req_en) check("burst_entry", req_get, q_req[0]);
      check("burst_ack", wb.ACK_O, exp_ack);
      if (exp_ack) check("burst_dat", wb.DAT_O, exp_dat);
      if (wb.ACK_O) dut_acks++;
      if (wb.STB_I && !exp_stall) begin
        q_req.push_back({1'b1, 4'hf, wb.ADR_I, wb.DAT_I});
        efifo++; sent++;
      end
      if (req_en) begin
        void'(q_req.pop_front());
        efifo--; elive++;
      end
      exp_ack = rsp_en;
      if (rsp_en) begin
        exp_dat = 32'h5000 + 32'(resp);
        resp++; elive--;
      end
    end
    check("burst_ack_count", dut_acks, 8);
    next(); idle_bus();

    // ---------------- error response followed by a normal one ----------------
    next(); wb.CYC_I = 1'b1; drive_req(1'b0, 32'h20, 32'h0); #1;
    check("err_stall", wb.STALL_O, 0);
    next(); drive_req(1'b0, 32'h24, 32'h0); req_en = 1'b1;
    next(); wb.STB_I = 1'b0; req_en = 1'b1;
    next(); req_en = 1'b0; rsp_en = 1'b1; rsp_put = {1'b1, 32'hDEAD0001};
    next(); rsp_put = {1'b0, 32'h12345678}; #1;
    check("err_err", wb.ERR_O, 1);
    check("err_ack", wb.ACK_O, 0);
    check("err_dat", wb.DAT_O, 32'hDEAD0001);
    next(); rsp_en = 1'b0; #1;
    check("err_next_ack", wb.ACK_O, 1);
    check("err_next_err", wb.ERR_O, 0);
    check("err_next_dat", wb.DAT_O, 32'h12345678);
    next(); #1;
    check("err_quiet_ack", wb.ACK_O, 0);
    check("err_quiet_err", wb.ERR_O, 0);

    // ---------------- abort with three popped requests ----------------
    next(); wb.CYC_I = 1'b1; drive_req(1'b0, 32'h30, 32'h0);
    next(); drive_req(1'b0, 32'h34, 32'h0); req_en = 1'b1;
    next(); drive_req(1'b0, 32'h38, 32'h0); req_en = 1'b1;
    next(); wb.STB_I = 1'b0; req_en = 1'b1;
    next(); req_en = 1'b0; wb.CYC_I = 1'b0; drive_req(1'b0, 32'h3C, 32'h0); #1;
    check("abort_stall",   wb.STALL_O, 0);
    check("abort_req_rdy", req_rdy,    0);
    check("abort_rsp_rdy", rsp_rdy,    1);
    next(); wb.CYC_I = 1'b1; drive_req(1'b0, 32'h40, 32'h0); #1;
    check("abort_new_stall",   wb.STALL_O, 0);
    check("abort_stb_ignored", req_rdy,    0);
    next(); wb.STB_I = 1'b0; req_en = 1'b1; #1;
    check("abort_new_entry", req_get, {1'b0, 4'hf, 32'h40, 32'h0});
    next(); req_en = 1'b0; rsp_en = 1'b1; rsp_put = {1'b0, 32'hBEEF0001};
    next(); rsp_put = {1'b0, 32'hBEEF0002}; #1;
    check("abort_stale1_ack", wb.ACK_O, 0);
    next(); rsp_put = {1'b0, 32'hBEEF0003}; #1;
    check("abort_stale2_ack", wb.ACK_O, 0);
    next(); rsp_put = {1'b0, 32'hBEEF0004}; #1;
    check("abort_stale3_ack", wb.ACK_O, 0);
    check("abort_stale_dat",  wb.DAT_O, 32'h12345678);
    check("abort_rsp_rdy4",   rsp_rdy,  1);
    next(); rsp_en = 1'b0; #1;
    check("abort_live_ack",   wb.ACK_O, 1);
    check("abort_live_dat",   wb.DAT_O, 32'hBEEF0004);
    check("abort_rsp_drained", rsp_rdy, 0);
    next(); idle_bus();

    // ---------------- full FIFO, then reset mid-burst ----------------
    next(); wb.CYC_I = 1'b1; drive_req(1'b1, 32'h50, 32'h11); #1;
    check("full_stall0", wb.STALL_O, 0);
    next(); drive_req(1'b1, 32'h54, 32'h22); #1;
    check("full_stall1", wb.STALL_O, 0);
    next(); drive_req(1'b1, 32'h58, 32'h33); req_en = 1'b1; #1;
    check("full_stall2", wb.STALL_O, 1);
    check("full_head",   req_get, {1'b1, 4'hf, 32'h50, 32'h11});
    next(); #1;
    check("full_after_pop_stall", wb.STALL_O, 0);
    check("full_head2",           req_get, {1'b1, 4'hf, 32'h54, 32'h22});
    next(); req_en = 1'b0; drive_req(1'b1, 32'h5C, 32'h44); #1;
    check("full_out3_stall", wb.STALL_O, 0);
    next(); #1;
    check("full_limit_stall", wb.STALL_O, 1);
    check("full_rsp_rdy",     rsp_rdy,    1);
    rst = 1'b1; rsp_en = 1'b1; rsp_put = {1'b0, 32'h77};
    next(); rst = 1'b0; wb.STB_I = 1'b0; rsp_en = 1'b0; #1;
    check("mrst_ack",     wb.ACK_O,   0);
    check("mrst_err",     wb.ERR_O,   0);
    check("mrst_dat",     wb.DAT_O,   0);
    check("mrst_stall",   wb.STALL_O, 0);
    check("mrst_req_rdy", req_rdy,    0);
    check("mrst_rsp_rdy", rsp_rdy,    0);

    next(); idle_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
